osd_dp_regsnap_sequencer: RTL and testbench
===========================================

Name: osd_dp_regsnap_sequencer

Overview:
- Sequences register-file snapshot reads from the core and merges the returned values into the debug processor's trace input as trace events.
- Sits between the core (trace stream and register read port) and the debug processor trace port (trace_valid/trace_id/trace_value).
- Live core trace always has priority; snapshot values are buffered and fill idle trace cycles.

Parameters:
- REG_ADDR_WIDTH, 5, core register file address width.
- XLEN, 64, register/trace value width.
- RD_LATENCY, 1, cycles from rf_read_en to rf_read_data valid (>=1, fixed).
- FIFO_DEPTH, 4, snapshot result buffer entries (power of 2, >=2).
- SNAP_ID_BASE, 16'hF000, trace_id of register 0; register n uses SNAP_ID_BASE+n.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- snap_start  in  1  start request pulse
- snap_first  in  REG_ADDR_WIDTH  first register address, sampled with snap_start
- snap_last  in  REG_ADDR_WIDTH  last register address, sampled with snap_start
- snap_busy  out  1  snapshot in progress
- snap_done  out  1  one-cycle pulse when the last value has left on trace
- core_trace_valid  in  1  live core trace event
- core_trace_id  in  16  live event id
- core_trace_value  in  XLEN  live event value
- rf_read_en  out  1  register read strobe to the core
- rf_read_addr  out  REG_ADDR_WIDTH  register read address
- rf_read_data  in  XLEN  read data, valid RD_LATENCY cycles after rf_read_en
- trace_valid  out  1  to debug processor
- trace_id  out  16  to debug processor
- trace_value  out  XLEN  to debug processor

Behaviour:
- Reset: all outputs 0; FSM to IDLE; FIFO empty; in-flight count 0.
- Output stage registered: trace_* update one cycle after the selected source.
- Arbitration per cycle:
  - core_trace_valid=1: forward core event.
  - Else, FIFO non-empty: pop one entry.
  - Else: trace_valid=0, trace_id/trace_value hold their previous values.
- Live core events are never dropped or delayed beyond the 1-cycle register.
- FSM IDLE:
  - snap_start=1: latch first/last, cur=first, go to ISSUE; snap_busy=1 from the next cycle.
- FSM ISSUE:
  - Assert rf_read_en with rf_read_addr=cur only when inflight+occupancy < FIFO_DEPTH (credit rule; no FIFO overflow possible).
  - On issue: cur=cur+1 modulo 2^REG_ADDR_WIDTH.
  - Issue of cur==last goes to DRAIN.
- FSM DRAIN:
  - Wait for inflight==0 and FIFO empty, then pulse snap_done for 1 cycle (same cycle the final trace_valid is visible, or later) and go to IDLE; snap_busy=0 in IDLE.
- Address range:
  - first==last: one read.
  - first>last: wraps through max address to last (e.g., W=5, first=30, last=1 reads 30,31,0,1).
- Read return: an RD_LATENCY-deep valid/address shift pipeline tags each return; push {SNAP_ID_BASE+addr, rf_read_data} on arrival.
- inflight counter:
  - +1 on issue, -1 on return, unchanged when both occur.
- FIFO occupancy:
  - Push and pop in the same cycle leaves occupancy unchanged.
  - Pop from empty never occurs (arbiter checks non-empty).
- snap_start while busy is ignored (no restart, no error).
- snap_start in the same cycle as the snap_done pulse is ignored; the FSM is not yet in IDLE.
- Back-to-back snapshots: minimum one IDLE cycle between snap_done and the next accepted start.
- Reset mid-snapshot: immediate return to reset state; in-flight returns after reset are discarded (pipeline cleared).
- trace_id arithmetic is 16-bit modulo: SNAP_ID_BASE+addr wraps.

Optional Feature:
- Macro OSD_DP_SNAP_ABORT_EN adds input port snap_abort (1 bit).
- With the macro, snap_abort=1 while busy:
  - Stops issuing.
  - Discards in-flight returns and flushes the FIFO.
  - Returns to IDLE next cycle with no snap_done pulse.
  - Live trace is unaffected.
  - snap_abort has priority over a simultaneous snap_start.
- Without the macro: port absent; a snapshot always runs to completion.

Test Plan:
- Quiet core, snap_first=0, snap_last=3, RD_LATENCY=1, rf_read_data=addr*16'h1111 -> four trace events, ids F000..F003, values 0,1111,2222,3333 in order; snap_done one pulse; snap_busy low afterwards.
- core_trace_valid held high 20 cycles during a 0..31 snapshot, FIFO_DEPTH=4 -> at most 4 reads outstanding+buffered; all core events forwarded 1 cycle later unchanged; snapshot values appear only after the core goes quiet; all 32 ids present, none duplicated.
- Same-cycle read return, FIFO pop and core event -> core event output; FIFO occupancy unchanged; no loss.
- snap_first=30, snap_last=1 -> reads 30,31,0,1; ids F01E,F01F,F000,F001.
- snap_start while busy, then rst asserted mid-DRAIN -> start ignored; after rst all outputs 0, no snap_done; a new snapshot completes normally.
- With OSD_DP_SNAP_ABORT_EN, snap_abort after 2 issues -> no further rf_read_en, no snap_done, snap_busy low next cycle, FIFO empty.

Source files
------------

// File: rtl/osd_dp_regsnap_sequencer.sv
// Register-file snapshot sequencer: issues credit-limited register reads and merges the
// returned values into idle cycles of the debug trace stream. Optional abort: OSD_DP_SNAP_ABORT_EN.
module osd_dp_regsnap_sequencer #(
    parameter int          REG_ADDR_WIDTH = 5,
    parameter int          XLEN           = 64,
    parameter int          RD_LATENCY     = 1,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [15:0] SNAP_ID_BASE   = 16'hF000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      snap_start,
    input  logic [REG_ADDR_WIDTH-1:0] snap_first,
    input  logic [REG_ADDR_WIDTH-1:0] snap_last,
    output logic                      snap_busy,
    output logic                      snap_done,
`ifdef OSD_DP_SNAP_ABORT_EN
    input  logic                      snap_abort,
`endif
    input  logic                      core_trace_valid,
    input  logic [15:0]               core_trace_id,
    input  logic [XLEN-1:0]           core_trace_value,
    output logic                      rf_read_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [XLEN-1:0]           rf_read_data,
    output logic                      trace_valid,
    output logic [15:0]               trace_id,
    output logic [XLEN-1:0]           trace_value
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 16 + XLEN;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic                      abort_w;
    logic [1:0]                state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [REG_ADDR_WIDTH-1:0] last_q, last_d;
    logic [CW-1:0]             inflight_q, inflight_d;
    logic [CW-1:0]             count_q, count_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]             mem_q [FIFO_DEPTH];
    logic [RD_LATENCY-1:0]     pipe_vld_q;
    logic [REG_ADDR_WIDTH-1:0] pipe_addr_q [RD_LATENCY];
    logic                      trace_valid_q;
    logic [15:0]               trace_id_q;
    logic [XLEN-1:0]           trace_value_q;

    logic          fifo_empty;
    logic          credit_ok;
    logic          issue;
    logic          ret;
    logic          push;
    logic          pop;
    logic          done_w;
    logic [EW-1:0] push_entry;

`ifdef OSD_DP_SNAP_ABORT_EN
    assign abort_w = snap_abort;
`else
    assign abort_w = 1'b0;
`endif

    // Credits cover both outstanding reads and buffered results, so a return always has room.
    assign fifo_empty = (count_q == '0);
    assign credit_ok  = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C;
    assign issue      = (state_q == ST_ISSUE) && credit_ok && !abort_w;
    assign ret        = pipe_vld_q[RD_LATENCY-1];
    assign push       = ret && !abort_w;
    assign pop        = !core_trace_valid && !fifo_empty && !abort_w;
    assign done_w     = (state_q == ST_DRAIN) && (inflight_q == '0) && fifo_empty && !abort_w;
    assign push_entry = {SNAP_ID_BASE + 16'(pipe_addr_q[RD_LATENCY-1]), rf_read_data};

    assign snap_busy    = (state_q != ST_IDLE);
    assign snap_done    = done_w;
    assign rf_read_en   = issue;
    assign rf_read_addr = cur_q;
    assign trace_valid  = trace_valid_q;
    assign trace_id     = trace_id_q;
    assign trace_value  = trace_value_q;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (snap_start) begin
                    cur_d   = snap_first;
                    last_d  = snap_last;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    cur_d = cur_q + 1'b1;
                    if (cur_q == last_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (done_w) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_w) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (issue && !ret) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue && ret) begin
            inflight_d = inflight_q - 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Abort drops everything buffered or still in flight.
        if (abort_w) begin
            inflight_d = '0;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            last_q     <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Each read carries its address down the pipe so the return can be tagged with its id.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_addr_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_addr_q[0] <= cur_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end
            if (abort_w) begin
                pipe_vld_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_valid_q <= 1'b0;
            trace_id_q    <= '0;
            trace_value_q <= '0;
        end else if (core_trace_valid) begin
            trace_valid_q <= 1'b1;
            trace_id_q    <= core_trace_id;
            trace_value_q <= core_trace_value;
        end else if (pop) begin
            trace_valid_q <= 1'b1;
            {trace_id_q, trace_value_q} <= mem_q[rd_ptr_q];
        end else begin
            trace_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_osd_dp_regsnap_sequencer.sv
// Scoreboard bench for osd_dp_regsnap_sequencer: a register-file model answers reads and a
// monitor checks every trace event, read address and done pulse against queued expectations.
module tb_osd_dp_regsnap_sequencer;

    localparam int W  = 5;
    localparam int XL = 64;

    typedef struct packed {
        logic [15:0]   id;
        logic [XL-1:0] val;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          snap_start;
    logic [W-1:0]  snap_first;
    logic [W-1:0]  snap_last;
    logic          snap_busy;
    logic          snap_done;
    logic          snap_abort;
    logic          core_trace_valid;
    logic [15:0]   core_trace_id;
    logic [XL-1:0] core_trace_value;
    logic          rf_read_en;
    logic [W-1:0]  rf_read_addr;
    logic [XL-1:0] rf_read_data = '0;
    logic          trace_valid;
    logic [15:0]   trace_id;
    logic [XL-1:0] trace_value;

    int checks    = 0;
    int errors    = 0;
    int doneCount = 0;
    int issued    = 0;
    int emitted   = 0;
    logic coreLive = 1'b0;

    ev_t          snapQ[$];
    ev_t          coreQ[$];
    logic [W-1:0] addrQ[$];

    always #5 clk = ~clk;

    osd_dp_regsnap_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .snap_start       (snap_start),
        .snap_first       (snap_first),
        .snap_last        (snap_last),
        .snap_busy        (snap_busy),
        .snap_done        (snap_done),
`ifdef OSD_DP_SNAP_ABORT_EN
        .snap_abort       (snap_abort),
`endif
        .core_trace_valid (core_trace_valid),
        .core_trace_id    (core_trace_id),
        .core_trace_value (core_trace_value),
        .rf_read_en       (rf_read_en),
        .rf_read_addr     (rf_read_addr),
        .rf_read_data     (rf_read_data),
        .trace_valid      (trace_valid),
        .trace_id         (trace_id),
        .trace_value      (trace_value)
    );

    function automatic logic [XL-1:0] regVal(input logic [W-1:0] a);
        return XL'(a) * 64'h1111;
    endfunction

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Register file model: answers each read one cycle later and checks the read order.
    always @(posedge clk) begin
        coreLive <= rst ? 1'b0 : core_trace_valid;
        if (!rst && rf_read_en) begin
            issued++;
            if (addrQ.size() == 0) begin
                checkOutput("unexpected_read", {75'd0, rf_read_addr}, 80'h0_FFFF);
            end else begin
                checkOutput("read_addr", {75'd0, rf_read_addr}, {75'd0, addrQ.pop_front()});
            end
            rf_read_data <= regVal(rf_read_addr);
        end
    end

    // Trace monitor: core events must appear exactly one cycle later; snapshot events in read order.
    always @(negedge clk) begin
        if (!rst) begin
            if (coreLive) begin
                checkOutput("core_latency", {78'd0, trace_valid, trace_id[15:8] == 8'hF0}, 80'd2);
            end
            if (trace_valid) begin
                if (trace_id[15:8] == 8'hF0) begin
                    emitted++;
                    if (snapQ.size() == 0) begin
                        checkOutput("unexpected_snap", {trace_id, trace_value}, 80'd0);
                    end else begin
                        checkOutput("snap_event", {trace_id, trace_value}, snapQ.pop_front());
                    end
                end else begin
                    if (coreQ.size() == 0) begin
                        checkOutput("unexpected_core", {trace_id, trace_value}, 80'd0);
                    end else begin
                        checkOutput("core_event", {trace_id, trace_value}, coreQ.pop_front());
                    end
                end
            end
            if (rf_read_en) begin
                checkOutput("credit_limit", 80'(issued + 1 - emitted > 4), 80'd0);
            end
            if (snap_done) begin
                doneCount++;
                checkOutput("done_pending", 80'(snapQ.size()), 80'd0);
            end
        end
    end

    task automatic applyStimulus(input logic st, input logic [W-1:0] f, input logic [W-1:0] l,
                                 input logic cv, input logic [15:0] cid, input logic [XL-1:0] cval);
        @(posedge clk);
        #1;
        snap_start       = st;
        snap_first       = f;
        snap_last        = l;
        core_trace_valid = cv;
        core_trace_id    = cid;
        core_trace_value = cval;
        if (cv) begin
            coreQ.push_back({cid, cval});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 16'd0, '0);
        end
    endtask

    task automatic startSnap(input logic [W-1:0] f, input logic [W-1:0] l);
        logic [W-1:0] a;
        a = f;
        forever begin
            addrQ.push_back(a);
            snapQ.push_back({16'hF000 + 16'(a), regVal(a)});
            if (a == l) break;
            a = a + 1'b1;
        end
        applyStimulus(1'b1, f, l, 1'b0, 16'd0, '0);
    endtask

    task automatic waitDone(input int expDone, input int maxCycles, input string name);
        int n;
        n = 0;
        while (doneCount < expDone && n < maxCycles) begin
            @(posedge clk);
            n++;
        end
        checkOutput(name, 80'(doneCount), 80'(expDone));
    endtask

    task automatic waitRead(input logic [W-1:0] a, input int maxCycles, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(rf_read_en && rf_read_addr == a) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {79'd0, rf_read_en && rf_read_addr == a}, 80'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_trace_valid"}, {79'd0, trace_valid}, 80'd0);
        checkOutput({tag, "_trace_id"}, {64'd0, trace_id}, 80'd0);
        checkOutput({tag, "_trace_value"}, {16'd0, trace_value}, 80'd0);
        checkOutput({tag, "_busy_done"}, {78'd0, snap_busy, snap_done}, 80'd0);
        checkOutput({tag, "_rf_read"}, {74'd0, rf_read_en, rf_read_addr}, 80'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        snap_start       = 1'b0;
        snap_first       = '0;
        snap_last        = '0;
        snap_abort       = 1'b0;
        core_trace_valid = 1'b0;
        core_trace_id    = '0;
        core_trace_value = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;
        idle(2);

        $display("[TB] quiet snapshot 0..3");
        startSnap(5'd0, 5'd3);
        idle(1);
        waitDone(1, 100, "done_quiet");
        #1;
        checkOutput("busy_after_done", {79'd0, snap_busy}, 80'd0);
        idle(2);
        checkOutput("trace_hold", {15'd0, trace_valid, trace_id, trace_value},
                    {15'd0, 1'b0, 16'hF003, 64'h3333});

        $display("[TB] snapshot 0..31 under 20 cycles of live trace");
        startSnap(5'd0, 5'd31);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 16'h1000 + 16'(i), 64'hC0DE_0000 + 64'(i));
        end
        idle(1);
        waitDone(2, 300, "done_full");

        $display("[TB] snapshot 0..7 with alternating live trace");
        startSnap(5'd0, 5'd7);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, '0, '0, 1'(i % 2), 16'h1100 + 16'(i), 64'hA5A5_0000 + 64'(i));
        end
        idle(1);
        waitDone(3, 200, "done_alternate");

        $display("[TB] wrapping snapshot 30..1");
        startSnap(5'd30, 5'd1);
        idle(1);
        waitDone(4, 100, "done_wrap");

        $display("[TB] start while busy, then reset in drain");
        startSnap(5'd0, 5'd3);
        applyStimulus(1'b1, 5'd10, 5'd12, 1'b0, 16'd0, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, 16'd0, '0);
        waitRead(5'd3, 20, "reach_last_read");
        @(posedge clk);
        #1;
        rst = 1'b1;
        snapQ.delete();
        addrQ.delete();
        issued  = 0;
        emitted = 0;
        #1;
        checkResetOutputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        checkOutput("no_done_after_rst", 80'(doneCount), 80'd4);
        startSnap(5'd5, 5'd6);
        idle(1);
        waitDone(5, 100, "done_after_rst");

`ifdef OSD_DP_SNAP_ABORT_EN
        $display("[TB] abort after two reads");
        startSnap(5'd0, 5'd7);
        idle(1);
        waitRead(5'd1, 20, "reach_second_read");
        @(posedge clk);
        #1;
        snap_abort = 1'b1;
        addrQ.delete();
        @(posedge clk);
        #1;
        snap_abort = 1'b0;
        snapQ.delete();
        issued  = 0;
        emitted = 0;
        checkOutput("busy_after_abort", {79'd0, snap_busy}, 80'd0);
        idle(10);
        checkOutput("no_done_after_abort", 80'(doneCount), 80'd5);
        startSnap(5'd4, 5'd5);
        idle(1);
        waitDone(6, 100, "done_after_abort");
`endif

        idle(3);
        checkOutput("snap_queue_empty", 80'(snapQ.size()), 80'd0);
        checkOutput("core_queue_empty", 80'(coreQ.size()), 80'd0);
        checkOutput("addr_queue_empty", 80'(addrQ.size()), 80'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
